dsp_stage_sequencer: RTL and testbench

//  Parametrised top-level controller that sequences a chain of DSP cores (band-pass filter, then FFT, ...).
//  It holds each core in reset, releases the cores in order and pulses a per-stage go signal.
//  It then waits for that stage's done, guarded by a per-stage timeout.

---
 rtl/dsp_seq_pkg.sv | 36 +++
 rtl/seq_timer.sv | 37 +++
 rtl/dsp_stage_sequencer.sv | 173 +++++++++++++++++
 tb/tb_dsp_stage_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared state encoding and sizing helpers for the DSP stage sequencer.
package dsp_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } seq_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned     result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < 64'(value)) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_stages);
        return (num_stages > 1) ? clog2(num_stages) : 1;
    endfunction

    // Bits needed to hold the value max_val itself.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/dsp_stage_sequencer.sv
// Sequences a chain of DSP cores: hold in reset, release in order, pulse go,
// wait for done under a watchdog; single-shot or free-running frames.
module dsp_stage_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int unsigned  NUM_STAGES = 2,
    parameter int unsigned  TIMEOUT    = 1023,
    parameter int unsigned  RST_CYCLES = 4,
    parameter int unsigned  FRAME_W    = 16,
    localparam int unsigned IDX_W      = idx_width(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  cont_mode_i,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic [NUM_STAGES-1:0] stage_go_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [IDX_W-1:0]      err_stage_o,
    output logic [FRAME_W-1:0]    frame_cnt_o
);

    localparam int unsigned      TMR_W    = cnt_width((TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic [NUM_STAGES-1:0]   stage_go_q, stage_go_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        err_stage_q, err_stage_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;

    logic hold_load, hold_zero;
    logic wd_zero;
    logic new_stage;
    logic go_cycle;
    logic done_sel;

    seq_timer #(.W(TMR_W)) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (hold_load),
        .load_val_i (TMR_W'(RST_CYCLES - 1)),
        .en_i       (state_q == ST_LOAD),
        .zero_o     (hold_zero)
    );

    // Watchdog restarts at every stage go; reaches zero on the TIMEOUT-th cycle after go.
    seq_timer #(.W(TMR_W)) u_wd_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (new_stage),
        .load_val_i (TMR_W'(TIMEOUT)),
        .en_i       (state_q == ST_RUN),
        .zero_o     (wd_zero)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        frame_d     = frame_q;
        hold_load   = 1'b0;
        new_stage   = 1'b0;
        go_cycle    = |stage_go_q;
        done_sel    = 1'b0;

        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            if (int'(idx_q) == k) begin
                done_sel = stage_done_i[k];
            end
        end

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (start_i) begin
                        state_d     = ST_LOAD;
                        hold_load   = 1'b1;
                        err_d       = 1'b0;
                        err_stage_d = '0;
                    end
                end
                ST_LOAD: begin
                    if (hold_zero) begin
                        state_d   = ST_RUN;
                        idx_d     = '0;
                        new_stage = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Done in the go cycle itself is stale and ignored.
                    if (!go_cycle && done_sel) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            frame_d = frame_q + FRAME_W'(1);
                        end else begin
                            idx_d     = idx_q + IDX_W'(1);
                            new_stage = 1'b1;
                        end
                    end else if (!go_cycle && wd_zero) begin
                        state_d     = ST_ERR;
                        err_d       = 1'b1;
                        err_stage_d = idx_q;
                    end
                end
                ST_DONE: begin
                    if (cont_mode_i) begin
                        state_d   = ST_LOAD;
                        hold_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d != ST_RUN) begin
            idx_d = '0;
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            stage_rst_d[k] = !((state_d == ST_RUN) && (k <= int'(idx_d)));
            stage_go_d[k]  = new_stage && (int'(idx_d) == k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            stage_rst_q <= '1;
            stage_go_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            stage_go_q  <= stage_go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            frame_q     <= frame_d;
        end
    end

    assign stage_rst_o = stage_rst_q;
    assign stage_go_o  = stage_go_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_stage_o = err_stage_q;
    assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_dsp_stage_sequencer.sv
// Self-checking bench: randomized core responses against a frame-timeline reference model.
module tb_dsp_stage_sequencer;

    localparam int unsigned NS = 2;
    localparam int unsigned T  = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned FW = 4;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          start_i      = 1'b0;
    logic          abort_i      = 1'b0;
    logic          cont_mode_i  = 1'b0;
    logic [NS-1:0] stage_done_i = '0;
    logic [NS-1:0] stage_rst_o;
    logic [NS-1:0] stage_go_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [0:0]    err_stage_o;
    logic [FW-1:0] frame_cnt_o;

    int          checks     = 0;
    int          passes     = 0;
    int          cyc        = 0;
    logic [FW-1:0] exp_frames = '0;

    dsp_stage_sequencer #(
        .NUM_STAGES (NS),
        .TIMEOUT    (T),
        .RST_CYCLES (R),
        .FRAME_W    (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .cont_mode_i  (cont_mode_i),
        .stage_done_i (stage_done_i),
        .stage_rst_o  (stage_rst_o),
        .stage_go_o   (stage_go_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_stage_o  (err_stage_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One frame: stage k answers d[k] cycles after its go (0 or >T = never).
    task automatic run_frame(input int d0, input int d1, input bit first, input bit cont,
                             input bit spur, input string tag);
        int d[2];
        int g[2];
        bit gv[2];
        int acc[2];
        int s, fin, fail_k;
        bit ok;
        logic [11:0] exp, got;
        logic [1:0]  e_go, e_rst;
        d[0] = d0; d[1] = d1;
        gv[0] = 1'b1; gv[1] = 1'b0;
        acc[0] = -1; acc[1] = -1;
        s = cyc; ok = 1'b1; fail_k = 0; fin = 0;
        g[0] = s + 1 + int'(R); g[1] = 0;
        for (int k = 0; k < 2; k++) begin
            if (ok) begin
                if (d[k] >= 1 && d[k] <= int'(T)) begin
                    acc[k] = g[k] + d[k];
                    if (k == 0) begin
                        g[1] = acc[0] + 1; gv[1] = 1'b1;
                    end else begin
                        fin = acc[k] + 1;
                    end
                end else begin
                    ok = 1'b0; fail_k = k; fin = g[k] + int'(T) + 1;
                end
            end
        end
        for (int c = s; c <= fin; c++) begin
            int cur;
            if (c > s) step();
            cur = -1;
            for (int k = 0; k < 2; k++)
                if (gv[k] && c >= g[k] && c < fin) cur = k;
            for (int k = 0; k < 2; k++) begin
                if (k == cur)
                    stage_done_i[k] = (c == g[k]) ? (spur | 1'($urandom_range(1))) : 1'(c == acc[k]);
                else
                    stage_done_i[k] = spur | 1'($urandom_range(1));
            end
            abort_i = 1'b0;
            if (c == s) begin
                if (first) start_i = 1'b1;
            end else begin
                start_i     = (c < fin) ? 1'($urandom_range(1)) : 1'b0;
                cont_mode_i = cont;
            end
            if (c > s) begin
                @(negedge clk);
                e_go = '0; e_rst = 2'b11;
                for (int k = 0; k < 2; k++) begin
                    if (gv[k] && c == g[k]) e_go[k] = 1'b1;
                    if (gv[k] && c >= g[k] && c < fin) e_rst[k] = 1'b0;
                end
                if (ok && c == fin) exp_frames = exp_frames + FW'(1);
                exp = {e_rst, e_go, 1'(c < fin), 1'(ok && c == fin), 1'(!ok && c == fin),
                       (!ok && c == fin) ? 1'(fail_k) : 1'b0, exp_frames};
                got = {stage_rst_o, stage_go_o, busy_o, done_o, err_o, err_stage_o, frame_cnt_o};
                checks++;
                if (got !== exp)
                    $display("FAIL %s cycle +%0d: got rst/go/busy/done/err/es/frm=%b required %b",
                             tag, c - s, got, exp);
                else
                    passes++;
            end
        end
        if (ok && !cont) begin
            step();
            start_i = 1'b0; stage_done_i = '0;
            @(negedge clk);
            checks++;
            if ({stage_rst_o, stage_go_o, busy_o, done_o, err_o, frame_cnt_o} !== {2'b11, 2'b00, 3'b000, exp_frames})
                $display("FAIL %s_idle_after: got %b %b %b frm=%0d required idle frm=%0d",
                         tag, stage_rst_o, stage_go_o, busy_o, frame_cnt_o, exp_frames);
            else
                passes++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_i = 1'($urandom_range(1)); abort_i = 1'($urandom_range(1));
            cont_mode_i = 1'($urandom_range(1)); stage_done_i = 2'($urandom_range(3));
            @(negedge clk);
            checks++;
            if ({stage_rst_o, stage_go_o, busy_o, done_o, err_o, err_stage_o, frame_cnt_o} !== 12'b11_00_0000_0000)
                $display("FAIL reset_values: got %b %b %b %b %b %b %0d required 11 00 0 0 0 0 0",
                         stage_rst_o, stage_go_o, busy_o, done_o, err_o, err_stage_o, frame_cnt_o);
            else
                passes++;
        end
        step();
        rst_n = 1'b1; start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            start_i = 1'b0; abort_i = 1'($urandom_range(1));
            cont_mode_i = 1'($urandom_range(1)); stage_done_i = 2'($urandom_range(3));
            @(negedge clk);
            checks++;
            if ({stage_rst_o, stage_go_o, busy_o, done_o, err_o, frame_cnt_o} !== 11'b11_00_000_0000)
                $display("FAIL idle_no_start: got rst=%b go=%b busy=%b done=%b err=%b required idle",
                         stage_rst_o, stage_go_o, busy_o, done_o, err_o);
            else
                passes++;
        end
        abort_i = 1'b0;
    endtask

    task automatic test_nominal();
        run_frame(7, 7, 1'b1, 1'b0, 1'b0, "nominal");
    endtask

    task automatic test_timeout();
        run_frame(3, 0, 1'b1, 1'b0, 1'b0, "timeout");
        for (int i = 0; i < 3; i++) begin
            step();
            start_i = 1'b0; stage_done_i = 2'($urandom_range(3));
            @(negedge clk);
            checks++;
            if ({stage_rst_o, busy_o, err_o, err_stage_o} !== 5'b11_0_1_1)
                $display("FAIL err_hold: got rst=%b busy=%b err=%b es=%b required 11 0 1 1",
                         stage_rst_o, busy_o, err_o, err_stage_o);
            else
                passes++;
        end
        run_frame(5, 2, 1'b1, 1'b0, 1'b0, "restart_from_err");
        run_frame(1, int'(T), 1'b1, 1'b0, 1'b0, "window_edges");
    endtask

    task automatic test_spurious();
        run_frame(0, 3, 1'b1, 1'b0, 1'b1, "spurious_stage0");
        step();
        abort_i = 1'b1; start_i = 1'b0;
        step();
        abort_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, err_o, err_stage_o, stage_rst_o} !== 5'b0_1_0_11)
            $display("FAIL abort_keeps_err: got busy=%b err=%b es=%b rst=%b required 0 1 0 11",
                     busy_o, err_o, err_stage_o, stage_rst_o);
        else
            passes++;
        run_frame(4, 0, 1'b1, 1'b0, 1'b1, "spurious_stage1");
    endtask

    task automatic test_continuous();
        run_frame(3, 3, 1'b1, 1'b1, 1'b0, "cont_first");
        for (int i = 0; i < 16; i++)
            run_frame(3, 3, 1'b0, 1'b1, 1'b0, "cont");
        run_frame(3, 3, 1'b0, 1'b0, 1'b0, "cont_last");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int a, b;
            a = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(T, 1));
            b = ($urandom_range(9) == 0) ? int'(T) + 1 : int'($urandom_range(T, 1));
            run_frame(a, b, 1'b1, 1'b0, 1'($urandom_range(1)), "random");
        end
        step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
    endtask

    task automatic test_abort();
        int s;
        s = cyc;
        start_i = 1'b1; cont_mode_i = 1'b0; stage_done_i = '0; abort_i = 1'b0;
        // stage 0 answers at +7 (go +5), stage 1 would answer at +12 (go +8)
        for (int c = s + 1; c <= s + 12; c++) begin
            step();
            start_i      = 1'b0;
            stage_done_i = {1'(c == s + 12), 1'(c == s + 7)};
            abort_i      = 1'(c == s + 12);
            if (c == s + 11) begin
                @(negedge clk);
                checks++;
                if ({busy_o, stage_rst_o} !== 3'b1_00)
                    $display("FAIL abort_prereq: got busy=%b rst=%b required 1 00", busy_o, stage_rst_o);
                else
                    passes++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            abort_i = 1'b0; stage_done_i = '0;
            @(negedge clk);
            checks++;
            if ({stage_rst_o, stage_go_o, busy_o, done_o, frame_cnt_o} !== {2'b11, 2'b00, 2'b00, exp_frames})
                $display("FAIL abort_with_done: got rst=%b go=%b busy=%b done=%b frm=%0d required 11 00 0 0 %0d",
                         stage_rst_o, stage_go_o, busy_o, done_o, frame_cnt_o, exp_frames);
            else
                passes++;
        end
        start_i = 1'b1; abort_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            start_i = 1'b0; abort_i = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy_o, stage_rst_o} !== 3'b0_11)
                $display("FAIL start_abort_idle: got busy=%b rst=%b required 0 11", busy_o, stage_rst_o);
            else
                passes++;
        end
    endtask

    task automatic test_reset_midrun();
        start_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            start_i = 1'b0; stage_done_i = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        exp_frames = '0;
        checks++;
        if ({stage_rst_o, stage_go_o, busy_o, done_o, err_o, frame_cnt_o} !== 11'b11_00_000_0000)
            $display("FAIL reset_midrun: got rst=%b go=%b busy=%b done=%b frm=%0d required idle frm=0",
                     stage_rst_o, stage_go_o, busy_o, done_o, frame_cnt_o);
        else
            passes++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            checks++;
            if ({busy_o, done_o, frame_cnt_o} !== 6'b00_0000)
                $display("FAIL after_midrun_reset: got busy=%b done=%b frm=%0d required 0 0 0",
                         busy_o, done_o, frame_cnt_o);
            else
                passes++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_spurious();
        test_continuous();
        test_random();
        test_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
